// File: rtl/ov7670_frame_capture.sv
// OV7670 RGB565 byte-stream capture: optional 2:1 decimation in both directions,
// RGB444 conversion and a linear frame-buffer write port with frame framing.
module ov7670_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIMATE = 1,
  parameter int MAX_ADDR = 76800
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  input  logic        capture_en,
  output logic [16:0] wraddress,
  output logic [11:0] data,
  output logic        wren,
  output logic        frame_done,
  output logic        overflow,
  output logic [7:0]  frame_count,
  output logic [1:0]  dbg_state
);
  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [16:0]   ADDR_END = 17'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2} state_t;
  state_t state, state_nxt;

  // Assert asynchronously, release on pclk so every flop leaves reset together.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic       vsync_s1, href_s1, vsync_q, href_q;
  logic [7:0] d_s1;
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1 <= 1'b0;
      href_s1  <= 1'b0;
      d_s1     <= '0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
    end else begin
      vsync_s1 <= vsync;
      href_s1  <= href;
      d_s1     <= d;
      vsync_q  <= vsync_s1;
      href_q   <= href_s1;
    end
  end

  logic vs_rise, vs_fall, href_fall;
  assign vs_rise   = vsync_s1 & ~vsync_q;
  assign vs_fall   = ~vsync_s1 & vsync_q;
  assign href_fall = ~href_s1 & href_q;

  logic start_frame, end_frame;
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    unique case (state)
      IDLE:   if (vs_rise) state_nxt = SYNC;
      SYNC:   if (vs_fall && capture_en) begin
                state_nxt   = ACTIVE;
                start_frame = 1'b1;
              end
      ACTIVE: if (vs_rise) begin
                state_nxt = SYNC;
                end_frame = 1'b1;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  assign dbg_state = state;

  logic          phase;
  logic [6:0]    hi;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          in_active, pix_done, keep;
  logic [11:0]   pix_data;

  assign in_active = (state == ACTIVE);
  // A pixel racing the end-of-frame vsync edge is dropped.
  assign pix_done  = in_active & href_s1 & phase & ~vs_rise;
  assign keep      = (DECIMATE == 0) || (!col[0] && !row[0]);
  assign pix_data  = {hi[6:3], hi[2:0], d_s1[7], d_s1[4:1]};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wraddress   <= '0;
      data        <= '0;
      wren        <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
      phase       <= 1'b0;
      hi          <= '0;
      col         <= '0;
      row         <= '0;
    end else begin
      wren       <= 1'b0;
      frame_done <= end_frame;
      if (end_frame) frame_count <= frame_count + 8'd1;
      if (start_frame) begin
        wraddress <= '0;
        col       <= '0;
        row       <= '0;
        overflow  <= 1'b0;
        phase     <= 1'b0;
      end else begin
        if (wren) wraddress <= wraddress + 17'd1;
        phase <= in_active & href_s1 & ~phase;
        if (in_active && href_s1 && !phase) hi <= {d_s1[7:4], d_s1[2:0]};
        if (pix_done) begin
          if (col != COL_LAST) col <= col + CW'(1);
          if (keep) begin
            if (wraddress != ADDR_END) begin
              wren <= 1'b1;
              data <= pix_data;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        // A dangling hi byte is simply forgotten: phase already returns to 0.
        if (in_active && href_fall) begin
          col <= '0;
          if (row != ROW_LAST) row <= row + RW'(1);
        end
      end
    end
  end
endmodule
